// File: rtl/mem_arb_pkg.sv
// Shared types for the memory-port arbiter: FSM state encoding and owner IDs.
package mem_arb_pkg;
  typedef enum logic {ARB_IDLE = 1'b0, ARB_ACCESS = 1'b1} arb_state_t;
  localparam logic OWNER_FETCH = 1'b0;
  localparam logic OWNER_DATA  = 1'b1;
endpackage

// File: rtl/mux_2NtoN.sv
// N-bit 2:1 mux used to steer the winning requester's address onto the port.
module mux_2NtoN #(
  parameter int N = 32
) (
  input  logic [N-1:0] i0,
  input  logic [N-1:0] i1,
  input  logic         s,
  output logic [N-1:0] y
);
  assign y = s ? i1 : i0;
endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin owner of the single memory port shared by fetch (0) and load/store (1);
// each grant holds the port for a fixed LAT-cycle window that cannot be aborted.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int N   = 32,
  parameter int LAT = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0,
  input  logic [N-1:0] addr0,
  input  logic         req1,
  input  logic [N-1:0] addr1,
  input  logic [N-1:0] wdata1,
  input  logic         we1,
  output logic         gnt0,
  output logic         gnt1,
  output logic         done0,
  output logic         done1,
  output logic         sel,
  output logic         mem_en,
  output logic         mem_we,
  output logic [N-1:0] mem_addr,
  output logic [N-1:0] mem_wdata
);
  localparam int            CW       = $clog2(LAT + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(LAT - 1);

  arb_state_t    state_q, state_d;
  logic          owner_q, owner_d;
  logic          last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic          done0_q, done0_d, done1_q, done1_d;
  logic          mem_en_q, mem_en_d;
  logic          other_req;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ARB_IDLE;
      owner_q  <= OWNER_FETCH;
      last_q   <= OWNER_DATA;
      cnt_q    <= '0;
      gnt0_q   <= 1'b0;
      gnt1_q   <= 1'b0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      mem_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      gnt0_q   <= gnt0_d;
      gnt1_q   <= gnt1_d;
      done0_q  <= done0_d;
      done1_q  <= done1_d;
      mem_en_q <= mem_en_d;
    end
  end

  // The finishing owner's own req is ignored in its done cycle; only the other side can chain.
  assign other_req = (owner_q == OWNER_FETCH) ? req1 : req0;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      ARB_IDLE: begin
        if (req0 || req1) begin
          state_d = ARB_ACCESS;
          owner_d = (req0 && req1) ? ~last_q : req1;
          cnt_d   = CNT_LOAD;
        end
      end
      ARB_ACCESS: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          last_d = owner_q;
          if (other_req) begin
            owner_d = ~owner_q;
            cnt_d   = CNT_LOAD;
          end else begin
            state_d = ARB_IDLE;
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // Registered outputs are decoded from next state so they line up with the state they describe.
  always_comb begin
    mem_en_d = (state_d == ARB_ACCESS);
    gnt0_d   = mem_en_d && (owner_d == OWNER_FETCH);
    gnt1_d   = mem_en_d && (owner_d == OWNER_DATA);
    done0_d  = gnt0_d && (cnt_d == '0);
    done1_d  = gnt1_d && (cnt_d == '0);
  end

  assign gnt0      = gnt0_q;
  assign gnt1      = gnt1_q;
  assign done0     = done0_q;
  assign done1     = done1_q;
  assign mem_en    = mem_en_q;
  assign sel       = owner_q;
  assign mem_we    = (state_q == ARB_ACCESS) && (owner_q == OWNER_DATA) && we1;
  assign mem_wdata = wdata1;

  mux_2NtoN #(.N(N)) u_addr_mux (
    .i0 (addr0),
    .i1 (addr1),
    .s  (owner_q),
    .y  (mem_addr)
  );
endmodule
